// File: rtl/dma_tx_msi_ctrl.sv
// Multi-channel MSI request controller for the DMA_TX path: sticky pending bits, round-robin
// arbitration, one MSI vector in flight at a time, bounded retry and a hold-off gap between requests.
module dma_tx_msi_ctrl #(
   parameter int CH_NUM    = 8,
   parameter int RETRY_MAX = 3,
   parameter int HOLDOFF   = 16
) (
   input  logic              user_clk,
   input  logic              reset_n,
   input  logic [CH_NUM-1:0] int_kick,
   input  logic [CH_NUM-1:0] int_mask,
   input  logic              int_msi_enb,
   input  logic              int_msi_sent,
   input  logic              int_msi_fail,
   output logic [31:0]       msi_int_user,
   output logic [CH_NUM-1:0] int_pending,
   output logic              int_busy,
   output logic [15:0]       int_drop_cnt
);
   localparam int CW  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   if (CH_NUM < 1 || CH_NUM > 32 || HOLDOFF < 1 || RETRY_MAX < 0 || RETRY_MAX > 15) begin : g_param_err
      $error("dma_tx_msi_ctrl: illegal parameter value");
   end

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

   state_t            r_state, w_state_next;
   logic [CH_NUM-1:0] r_pend, w_pend_next;
   logic [CH_NUM-1:0] r_mask;
   logic [31:0]       r_msi, w_msi_next;
   logic [CW-1:0]     r_cur, w_cur_next;
   logic [CW-1:0]     r_rr, w_rr_next;
   logic [3:0]        r_retry, w_retry_next;
   logic              r_again, w_again_next;
   logic [HCW-1:0]    r_hold_cnt, w_hold_next;
   logic [15:0]       r_drop_cnt, w_drop_next;
   logic [CH_NUM-1:0] w_cand;
   logic [CH_NUM-1:0] w_clr;
   logic [CW-1:0]     w_sel;
   logic [CW-1:0]     w_cur_inc;
   logic              w_found;

   // Mask is registered so that an unmask lines up with the registered pending bits (2-cycle latency).
   always_comb begin
      int idx;
      idx     = 0;
      w_cand  = r_pend & ~r_mask;
      w_sel   = r_rr;
      w_found = 1'b0;
      for (int k = 0; k < CH_NUM; k++) begin
         idx = int'(r_rr) + k;
         if (idx >= CH_NUM) idx = idx - CH_NUM;
         if (!w_found && w_cand[CW'(idx)]) begin
            w_found = 1'b1;
            w_sel   = CW'(idx);
         end
      end
   end

   assign w_cur_inc = (r_cur == CW'(CH_NUM - 1)) ? '0 : r_cur + 1'b1;

   always_comb begin
      w_state_next = r_state;
      w_msi_next   = r_msi;
      w_cur_next   = r_cur;
      w_rr_next    = r_rr;
      w_retry_next = r_retry;
      w_again_next = r_again;
      w_hold_next  = r_hold_cnt;
      w_drop_next  = r_drop_cnt;
      w_clr        = '0;
      case (r_state)
         S_IDLE: begin
            if (int_msi_enb && w_found) begin
               w_cur_next   = w_sel;
               w_msi_next   = 32'd1 << w_sel;
               w_retry_next = '0;
               w_again_next = 1'b0;
               w_state_next = S_REQ;
            end
         end
         S_REQ: begin
            if (int_msi_sent) begin
               w_clr[r_cur] = 1'b1;
               w_msi_next   = '0;
               w_rr_next    = w_cur_inc;
               w_again_next = 1'b0;
               w_hold_next  = '0;
               w_state_next = S_HOLD;
            end else if (int_msi_fail) begin
               w_msi_next   = '0;
               w_hold_next  = '0;
               w_state_next = S_HOLD;
               if (r_retry != 4'(RETRY_MAX)) begin
                  w_retry_next = r_retry + 4'd1;
                  w_again_next = 1'b1;
               end else begin
                  w_clr[r_cur] = 1'b1;
                  w_rr_next    = w_cur_inc;
                  w_again_next = 1'b0;
                  if (r_drop_cnt != 16'hFFFF) w_drop_next = r_drop_cnt + 16'd1;
               end
            end else if (!int_msi_enb) begin
               w_msi_next   = '0;
               w_retry_next = '0;
               w_state_next = S_IDLE;
            end
         end
         S_HOLD: begin
            if (r_hold_cnt == HCW'(HOLDOFF - 1)) begin
               w_again_next = 1'b0;
               if (r_again && int_msi_enb) begin
                  w_msi_next   = 32'd1 << r_cur;
                  w_state_next = S_REQ;
               end else begin
                  w_retry_next = '0;
                  w_state_next = S_IDLE;
               end
            end else begin
               w_hold_next = r_hold_cnt + 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // A kick coinciding with the clear wins, so no interrupt is lost.
   assign w_pend_next = (r_pend & ~w_clr) | int_kick;

   always_ff @(posedge user_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_pend     <= '0;
         r_mask     <= '1;
         r_msi      <= '0;
         r_cur      <= '0;
         r_rr       <= '0;
         r_retry    <= '0;
         r_again    <= 1'b0;
         r_hold_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_pend     <= w_pend_next;
         r_mask     <= int_mask;
         r_msi      <= w_msi_next;
         r_cur      <= w_cur_next;
         r_rr       <= w_rr_next;
         r_retry    <= w_retry_next;
         r_again    <= w_again_next;
         r_hold_cnt <= w_hold_next;
         r_drop_cnt <= w_drop_next;
      end
   end

   assign msi_int_user = r_msi;
   assign int_pending  = r_pend;
   assign int_busy     = (r_state != S_IDLE);
   assign int_drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_dma_tx_msi_ctrl.sv
// Scoreboard bench for dma_tx_msi_ctrl: expected vectors are queued at kick time and
// compared when each new MSI request appears.
module tb_dma_tx_msi_ctrl;
   localparam int CH_NUM    = 8;
   localparam int RETRY_MAX = 3;
   localparam int HOLDOFF   = 16;

   logic              user_clk = 1'b0;
   logic              reset_n;
   logic [CH_NUM-1:0] int_kick;
   logic [CH_NUM-1:0] int_mask;
   logic              int_msi_enb;
   logic              int_msi_sent;
   logic              int_msi_fail;
   logic [31:0]       msi_int_user;
   logic [CH_NUM-1:0] int_pending;
   logic              int_busy;
   logic [15:0]       int_drop_cnt;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] prev_msi = 32'd0;

   dma_tx_msi_ctrl #(.CH_NUM(CH_NUM), .RETRY_MAX(RETRY_MAX), .HOLDOFF(HOLDOFF)) dut (
      .user_clk    (user_clk),
      .reset_n     (reset_n),
      .int_kick    (int_kick),
      .int_mask    (int_mask),
      .int_msi_enb (int_msi_enb),
      .int_msi_sent(int_msi_sent),
      .int_msi_fail(int_msi_fail),
      .msi_int_user(msi_int_user),
      .int_pending (int_pending),
      .int_busy    (int_busy),
      .int_drop_cnt(int_drop_cnt)
   );

   always #5 user_clk = ~user_clk;

   function automatic void check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endfunction

   // Each new request (rising from zero) is one transaction.
   always @(negedge user_clk) begin
      if (msi_int_user != 32'd0 && prev_msi == 32'd0) begin
         if (exp_q.size() == 0) begin
            check_val("unexp_req", msi_int_user, 32'd0);
         end else begin
            $display("req vec=0x%0h exp=0x%0h", msi_int_user, exp_q[0]);
            check_val("req_vec", msi_int_user, exp_q.pop_front());
         end
      end
      prev_msi = msi_int_user;
   end

   task automatic tick();
      @(posedge user_clk);
      #1;
   endtask

   task automatic kick(input logic [CH_NUM-1:0] v);
      int_kick = v;
      tick();
      int_kick = '0;
   endtask

   task automatic wait_req(input string tag, input logic [31:0] exp, output int n);
      n = 0;
      while (msi_int_user == 32'd0 && n < 300) begin
         tick();
         n++;
      end
      if (msi_int_user == 32'd0) check_val(tag, msi_int_user, exp);
   endtask

   task automatic close(input bit fail);
      if (fail) int_msi_fail = 1'b1;
      else      int_msi_sent = 1'b1;
      tick();
      int_msi_sent = 1'b0;
      int_msi_fail = 1'b0;
   endtask

   task automatic serve(input string tag, input logic [31:0] exp, input bit fail);
      int n;
      wait_req(tag, exp, n);
      close(fail);
   endtask

   initial begin
      int n;
      reset_n = 1'b0; int_kick = '0; int_mask = '0;
      int_msi_enb = 1'b1; int_msi_sent = 1'b0; int_msi_fail = 1'b0;
      tick(); tick();
      check_val("rst_msi",  msi_int_user, 32'd0);
      check_val("rst_pend", 32'(int_pending), 32'd0);
      check_val("rst_busy", 32'(int_busy), 32'd0);
      check_val("rst_drop", 32'(int_drop_cnt), 32'd0);
      reset_n = 1'b1;
      tick(); tick();

      // Single request, latency and hold-off gap
      exp_q.push_back(32'h04);
      kick(8'h04);
      check_val("t1_pend_t1", 32'(int_pending), 32'h04);
      check_val("t1_msi_t1", msi_int_user, 32'd0);
      tick();
      check_val("t1_msi_t2", msi_int_user, 32'h04);
      tick(); tick(); tick();
      check_val("t1_msi_t5", msi_int_user, 32'h04);
      close(1'b0);
      check_val("t1_pend_t6", 32'(int_pending), 32'd0);
      check_val("t1_msi_t6", msi_int_user, 32'd0);
      check_val("t1_busy_t6", 32'(int_busy), 32'd1);
      exp_q.push_back(32'h08);
      kick(8'h08);
      wait_req("t1_req2", 32'h08, n);
      check_val("t1_holdoff", 32'(n), 32'(HOLDOFF));
      close(1'b0);

      // Round robin starting at pointer 4, then at pointer 0
      exp_q.push_back(32'h20); exp_q.push_back(32'h01); exp_q.push_back(32'h08);
      kick(8'h29);
      serve("t2a_0", 32'h20, 1'b0);
      serve("t2a_1", 32'h01, 1'b0);
      serve("t2a_2", 32'h08, 1'b0);
      exp_q.push_back(32'h80);
      kick(8'h80);
      serve("t2_ch7", 32'h80, 1'b0);
      exp_q.push_back(32'h01); exp_q.push_back(32'h08); exp_q.push_back(32'h20);
      kick(8'h29);
      serve("t2b_0", 32'h01, 1'b0);
      serve("t2b_1", 32'h08, 1'b0);
      serve("t2b_2", 32'h20, 1'b0);
      check_val("t2_pend", 32'(int_pending), 32'd0);

      // Retry exhaustion and drop
      for (int i = 0; i <= RETRY_MAX; i++) exp_q.push_back(32'h02);
      kick(8'h02);
      for (int i = 0; i <= RETRY_MAX; i++) serve("t3_retry", 32'h02, 1'b1);
      check_val("t3_pend", 32'(int_pending), 32'd0);
      check_val("t3_drop", 32'(int_drop_cnt), 32'd1);
      for (int i = 0; i < HOLDOFF + 6; i++) tick();
      check_val("t3_no5th", msi_int_user, 32'd0);
      check_val("t3_idle", 32'(int_busy), 32'd0);

      // Kick colliding with the sent cycle
      exp_q.push_back(32'h10); exp_q.push_back(32'h10);
      kick(8'h10);
      wait_req("t4_req1", 32'h10, n);
      int_kick = 8'h10;
      close(1'b0);
      int_kick = '0;
      check_val("t4_pend_kept", 32'(int_pending), 32'h10);
      serve("t4_req2", 32'h10, 1'b0);
      check_val("t4_pend_clr", 32'(int_pending), 32'd0);

      // Masked channel, unmask latency, enable drop in REQ
      int_mask = 8'h40;
      kick(8'h40);
      for (int i = 0; i < HOLDOFF + 4; i++) tick();
      check_val("t5_pend", 32'(int_pending), 32'h40);
      check_val("t5_masked", msi_int_user, 32'd0);
      exp_q.push_back(32'h40);
      int_mask = '0;
      tick();
      check_val("t5_unmask_1", msi_int_user, 32'd0);
      tick();
      check_val("t5_unmask_2", msi_int_user, 32'h40);
      int_msi_enb = 1'b0;
      tick();
      check_val("t5_enb_msi", msi_int_user, 32'd0);
      check_val("t5_enb_pend", 32'(int_pending), 32'h40);
      check_val("t5_enb_busy", 32'(int_busy), 32'd0);
      tick(); tick();
      check_val("t5_dis_msi", msi_int_user, 32'd0);
      exp_q.push_back(32'h40);
      int_msi_enb = 1'b1;
      serve("t5_reenb", 32'h40, 1'b0);

      // Asynchronous reset during REQ
      exp_q.push_back(32'h01);
      kick(8'h01);
      wait_req("t6_req", 32'h01, n);
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      check_val("t6_rst_msi", msi_int_user, 32'd0);
      check_val("t6_rst_pend", 32'(int_pending), 32'd0);
      check_val("t6_rst_busy", 32'(int_busy), 32'd0);
      tick(); tick();
      reset_n = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      check_val("t6_quiet", msi_int_user, 32'd0);
      check_val("t6_drop", 32'(int_drop_cnt), 32'd0);
      exp_q.push_back(32'h04);
      kick(8'h04);
      serve("t6_newkick", 32'h04, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      check_val("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
